module_bpu_gshare: RTL and testbench

Parametrised branch prediction unit for the pipelined RV32I core: a direct-mapped branch target buffer (BTB) plus a gshare pattern history table (PHT) of 2-bit saturating counters, indexed by PC XOR global history register (GHR). Fetch performs a same-cycle lookup and receives a predicted direction and target. Execute returns the resolved outcome one update per cycle, which trains the tables. Successor to the fixed single-table predictor, with configurable depth and history length, a BTB flush, a bypass mode and built-in performance counters.

---
 rtl/module_bpu_gshare.sv | 137 +++++++++++++
 tb/tb_module_bpu_gshare.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_bpu_gshare.sv
// Branch prediction unit: direct-mapped BTB plus gshare PHT of 2-bit counters.
// Same-cycle fetch lookup, one resolved update per cycle from execute.
module module_bpu_gshare #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BTB_IDX_BITS = 4,
    parameter int unsigned PHT_IDX_BITS = 6,
    parameter int unsigned GHR_BITS     = 4,
    parameter int unsigned CNT_BITS     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [XLEN-1:0]         pc_f_i,
    output logic                    predict_taken_f_o,
    output logic [XLEN-1:0]         target_f_o,
    output logic [PHT_IDX_BITS-1:0] pht_idx_f_o,
    input  logic                    upd_valid_e_i,
    input  logic [XLEN-1:0]         upd_pc_e_i,
    input  logic                    upd_jump_e_i,
    input  logic                    upd_taken_e_i,
    input  logic [XLEN-1:0]         upd_target_e_i,
    input  logic [PHT_IDX_BITS-1:0] pht_idx_e_i,
    input  logic                    mispredict_e_i,
    input  logic                    flush_i,
    output logic [CNT_BITS-1:0]     branch_cnt_o,
    output logic [CNT_BITS-1:0]     mispredict_cnt_o
);

    localparam int unsigned BTB_N = 1 << BTB_IDX_BITS;
    localparam int unsigned PHT_N = 1 << PHT_IDX_BITS;
    localparam int unsigned TAG_W = XLEN - BTB_IDX_BITS - 2;

    logic [BTB_N-1:0]        btb_valid;
    logic [TAG_W-1:0]        btb_tag    [BTB_N];
    logic [XLEN-1:0]         btb_target [BTB_N];
    logic [BTB_N-1:0]        btb_jump;
    logic [1:0]              pht        [PHT_N];
    logic [PHT_IDX_BITS-1:0] ghr_ext;

    logic [BTB_IDX_BITS-1:0] btb_idx_f;
    logic [BTB_IDX_BITS-1:0] btb_idx_e;
    logic                    btb_hit_f;
    logic                    upd_branch;
    logic                    unused_pc_bits;

    assign unused_pc_bits = ^{pc_f_i[1:0], upd_pc_e_i[1:0]};

    assign upd_branch = upd_valid_e_i & ~upd_jump_e_i;

    // History is committed only at resolution; bimodal when GHR_BITS is zero.
    if (GHR_BITS > 0) begin : g_ghr
        logic [GHR_BITS-1:0] ghr;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                ghr <= '0;
            end else if (upd_branch) begin
                ghr <= GHR_BITS'({ghr, upd_taken_e_i});
            end
        end

        if (GHR_BITS == PHT_IDX_BITS) begin : g_full
            assign ghr_ext = ghr;
        end else begin : g_pad
            assign ghr_ext = {{(PHT_IDX_BITS - GHR_BITS){1'b0}}, ghr};
        end
    end else begin : g_bimodal
        assign ghr_ext = '0;
    end

    // Fetch lookup
    always_comb begin
        btb_idx_f   = pc_f_i[BTB_IDX_BITS+1:2];
        pht_idx_f_o = pc_f_i[PHT_IDX_BITS+1:2] ^ ghr_ext;
        btb_hit_f   = btb_valid[btb_idx_f] &&
                      (btb_tag[btb_idx_f] == pc_f_i[XLEN-1:BTB_IDX_BITS+2]);
        predict_taken_f_o = enable_i & btb_hit_f &
                            (btb_jump[btb_idx_f] | pht[pht_idx_f_o][1]);
        target_f_o  = btb_hit_f ? btb_target[btb_idx_f] : '0;
    end

    assign btb_idx_e = upd_pc_e_i[BTB_IDX_BITS+1:2];

    // Valid bits carry the reset and flush; flush overrides a same-cycle write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            btb_valid <= '0;
        end else begin
            if (upd_valid_e_i && upd_taken_e_i) begin
                btb_valid[btb_idx_e] <= 1'b1;
            end
            if (flush_i) begin
                btb_valid <= '0;
            end
        end
    end

    // Entry payload is only observed through a set valid bit, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (upd_valid_e_i && upd_taken_e_i) begin
            btb_tag[btb_idx_e]    <= upd_pc_e_i[XLEN-1:BTB_IDX_BITS+2];
            btb_target[btb_idx_e] <= upd_target_e_i;
            btb_jump[btb_idx_e]   <= upd_jump_e_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (upd_branch) begin
            if (upd_taken_e_i) begin
                if (pht[pht_idx_e_i] != 2'b11) begin
                    pht[pht_idx_e_i] <= pht[pht_idx_e_i] + 2'd1;
                end
            end else if (pht[pht_idx_e_i] != 2'b00) begin
                pht[pht_idx_e_i] <= pht[pht_idx_e_i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else if (upd_valid_e_i) begin
            if (branch_cnt_o != '1) begin
                branch_cnt_o <= branch_cnt_o + 1'b1;
            end
            if (mispredict_e_i && (mispredict_cnt_o != '1)) begin
                mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_module_bpu_gshare.sv
// Randomized and directed checks of module_bpu_gshare against an array-based model.
module tb_module_bpu_gshare;

    localparam int unsigned BI   = 4;
    localparam int unsigned PI   = 6;
    localparam int unsigned G    = 4;
    localparam int unsigned NB   = 1 << BI;
    localparam int unsigned NP   = 1 << PI;
    localparam int unsigned CMAX = 15;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic [31:0]   pc_f_i;
    logic          predict_taken_f_o;
    logic [31:0]   target_f_o;
    logic [PI-1:0] pht_idx_f_o;
    logic          upd_valid_e_i;
    logic [31:0]   upd_pc_e_i;
    logic          upd_jump_e_i;
    logic          upd_taken_e_i;
    logic [31:0]   upd_target_e_i;
    logic [PI-1:0] pht_idx_e_i;
    logic          mispredict_e_i;
    logic          flush_i;
    logic [3:0]    branch_cnt_o;
    logic [3:0]    mispredict_cnt_o;

    module_bpu_gshare #(
        .XLEN(32), .BTB_IDX_BITS(BI), .PHT_IDX_BITS(PI), .GHR_BITS(G), .CNT_BITS(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .pc_f_i(pc_f_i),
        .predict_taken_f_o(predict_taken_f_o), .target_f_o(target_f_o),
        .pht_idx_f_o(pht_idx_f_o), .upd_valid_e_i(upd_valid_e_i),
        .upd_pc_e_i(upd_pc_e_i), .upd_jump_e_i(upd_jump_e_i),
        .upd_taken_e_i(upd_taken_e_i), .upd_target_e_i(upd_target_e_i),
        .pht_idx_e_i(pht_idx_e_i), .mispredict_e_i(mispredict_e_i),
        .flush_i(flush_i), .branch_cnt_o(branch_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    bit          m_valid [NB];
    logic [31:0] m_tagv  [NB];
    logic [31:0] m_tgt   [NB];
    bit          m_jump  [NB];
    int          m_pht   [NP];
    int          m_ghr;
    int          m_bc;
    int          m_mc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned m_bidx(input logic [31:0] pc);
        return (pc >> 2) % NB;
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] pc);
        return pc >> (BI + 2);
    endfunction

    function automatic int unsigned m_pidx(input logic [31:0] pc);
        return ((pc >> 2) % NP) ^ m_ghr;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < NP; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    task automatic model_edge();
        int unsigned b;
        int unsigned p;
        if (upd_valid_e_i) begin
            if (!upd_jump_e_i) begin
                p = pht_idx_e_i;
                if (upd_taken_e_i) m_pht[p] = (m_pht[p] < 3) ? m_pht[p] + 1 : 3;
                else               m_pht[p] = (m_pht[p] > 0) ? m_pht[p] - 1 : 0;
                m_ghr = (m_ghr * 2 + int'(upd_taken_e_i)) % (1 << G);
            end
            if (upd_taken_e_i) begin
                b = m_bidx(upd_pc_e_i);
                m_valid[b] = 1'b1;
                m_tagv[b]  = m_tag(upd_pc_e_i);
                m_tgt[b]   = upd_target_e_i;
                m_jump[b]  = upd_jump_e_i;
            end
            if (m_bc < CMAX) m_bc++;
            if (mispredict_e_i && m_mc < CMAX) m_mc++;
        end
        if (flush_i) for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_lookup();
        int unsigned b;
        bit hit;
        bit exp_pred;
        b   = m_bidx(pc_f_i);
        hit = m_valid[b] && (m_tagv[b] == m_tag(pc_f_i));
        exp_pred = enable_i && hit && (m_jump[b] || m_pht[m_pidx(pc_f_i)] >= 2);
        chk("pred", 64'(predict_taken_f_o), 64'(exp_pred));
        chk("target", 64'(target_f_o), hit ? 64'(m_tgt[b]) : 64'd0);
        chk("pht_idx", 64'(pht_idx_f_o), 64'(m_pidx(pc_f_i)));
        chk("branch_cnt", 64'(branch_cnt_o), 64'(m_bc));
        chk("mispredict_cnt", 64'(mispredict_cnt_o), 64'(m_mc));
    endtask

    // Called at posedge+1: look up at mid-cycle, then commit the edge to the model.
    task automatic tick();
        #3;
        check_lookup();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle();
        upd_valid_e_i  = 1'b0;
        upd_jump_e_i   = 1'b0;
        upd_taken_e_i  = 1'b0;
        upd_pc_e_i     = '0;
        upd_target_e_i = '0;
        pht_idx_e_i    = '0;
        mispredict_e_i = 1'b0;
        flush_i        = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #2;
        chk("rst_pred", 64'(predict_taken_f_o), 64'd0);
        chk("rst_target", 64'(target_f_o), 64'd0);
        m_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        idle();
    endtask

    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                       input logic [31:0] tgt, input logic [PI-1:0] pidx,
                       input logic mp, input logic fl);
        upd_valid_e_i  = 1'b1;
        upd_pc_e_i     = pc;
        upd_jump_e_i   = jmp;
        upd_taken_e_i  = tkn;
        upd_target_e_i = tgt;
        pht_idx_e_i    = pidx;
        mispredict_e_i = mp;
        flush_i        = fl;
        tick();
        idle();
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic en,
                        input logic exp_pred, input logic [31:0] exp_tgt);
        idle();
        pc_f_i   = pc;
        enable_i = en;
        #3;
        chk({tag, "_pred"}, 64'(predict_taken_f_o), 64'(exp_pred));
        chk({tag, "_target"}, 64'(target_f_o), 64'(exp_tgt));
        tick();
        enable_i = 1'b1;
    endtask

    task automatic clear_ghr();
        for (int i = 0; i < G; i++) upd(32'h1000, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h4;
            2: return 32'h40;
            3: return 32'h440;
            4: return 32'h20;
            default: return 32'($urandom_range(0, 1023)) << 2;
        endcase
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_r;
        int bc_before;
        idle();
        enable_i = 1'b1;
        pc_f_i   = 32'h100;
        rst_i    = 1'b0;
        m_reset();
        @(posedge clk_i);
        #1;
        do_reset();

        // Reset state
        look("reset", 32'h100, 1'b1, 1'b0, 32'h0);
        chk("reset_bcnt", 64'(branch_cnt_o), 64'd0);
        chk("reset_mcnt", 64'(mispredict_cnt_o), 64'd0);
        chk("reset_pidx", 64'(pht_idx_f_o), 64'h00);

        // Training of a conditional branch
        upd(32'h40, 1'b0, 1'b1, 32'h80, 6'h10, 1'b0, 1'b0);
        upd(32'h40, 1'b0, 1'b1, 32'h80, 6'h10, 1'b0, 1'b0);
        clear_ghr();
        look("train_taken", 32'h40, 1'b1, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 1'b0, 32'h0, 6'h10, 1'b0, 1'b0);
        upd(32'h40, 1'b0, 1'b0, 32'h0, 6'h10, 1'b0, 1'b0);
        look("train_nt", 32'h40, 1'b1, 1'b0, 32'h80);

        // Jump and bypass
        upd(32'h20, 1'b1, 1'b1, 32'h200, 6'h2A, 1'b0, 1'b0);
        look("jump", 32'h20, 1'b1, 1'b1, 32'h200);
        look("bypass", 32'h20, 1'b0, 1'b0, 32'h200);

        // Aliasing on BTB index 0, then flush against a same-cycle write
        upd(32'h440, 1'b0, 1'b1, 32'h900, 6'h11, 1'b0, 1'b0);
        look("alias", 32'h40, 1'b1, 1'b0, 32'h0);
        bc_before = int'(branch_cnt_o);
        upd(32'h40, 1'b0, 1'b1, 32'h80, 6'h10, 1'b0, 1'b1);
        look("flush", 32'h40, 1'b1, 1'b0, 32'h0);
        chk("flush_bcnt", 64'(branch_cnt_o), 64'(bc_before + 1));

        // Counter saturation
        for (int i = 0; i < 20; i++) upd(32'h1000, 1'b0, 1'b0, 32'h0, 6'h3F, 1'b1, 1'b0);
        look("sat", 32'h1000, 1'b1, 1'b0, 32'h0);
        chk("sat_bcnt", 64'(branch_cnt_o), 64'hF);
        chk("sat_mcnt", 64'(mispredict_cnt_o), 64'hF);

        // PHT counter saturates at 11: one decrement still predicts taken
        do_reset();
        for (int i = 0; i < 5; i++) upd(32'h0, 1'b0, 1'b1, 32'h300, 6'h00, 1'b0, 1'b0);
        clear_ghr();
        look("pht_sat", 32'h0, 1'b1, 1'b1, 32'h300);
        upd(32'h0, 1'b0, 1'b0, 32'h0, 6'h00, 1'b0, 1'b0);
        clear_ghr();
        look("pht_sat_dec", 32'h0, 1'b1, 1'b1, 32'h300);

        // GHR indexing: history 1,0,1,1 -> 0xB
        do_reset();
        upd(32'h0, 1'b0, 1'b1, 32'h300, 6'h00, 1'b0, 1'b0);
        upd(32'h0, 1'b0, 1'b0, 32'h0,   6'h00, 1'b0, 1'b0);
        upd(32'h0, 1'b0, 1'b1, 32'h300, 6'h00, 1'b0, 1'b0);
        upd(32'h0, 1'b0, 1'b1, 32'h300, 6'h00, 1'b0, 1'b0);
        pc_f_i = 32'h0;
        #2;
        chk("ghr_pidx0", 64'(pht_idx_f_o), 64'h0B);
        pc_f_i = 32'h4;
        #2;
        chk("ghr_pidx4", 64'(pht_idx_f_o), 64'h0A);
        #2;

        // Reset held across an edge discards the pending update
        @(posedge clk_i);
        #1;
        upd_valid_e_i = 1'b1;
        upd_pc_e_i    = 32'h40;
        upd_taken_e_i = 1'b1;
        upd_target_e_i = 32'h80;
        mispredict_e_i = 1'b1;
        do_reset();
        look("rst_discard", 32'h40, 1'b1, 1'b0, 32'h0);
        chk("rst_discard_bcnt", 64'(branch_cnt_o), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                upd_valid_e_i = 1'b1;
                do_reset();
            end
            enable_i       = ($urandom_range(0, 3) != 0);
            pc_f_i         = rand_pc();
            upd_valid_e_i  = ($urandom_range(0, 2) != 0);
            pc_r           = rand_pc();
            upd_pc_e_i     = pc_r;
            upd_jump_e_i   = ($urandom_range(0, 4) == 0);
            upd_taken_e_i  = ($urandom_range(0, 2) != 0);
            upd_target_e_i = 32'($urandom_range(0, 4095)) << 2;
            pht_idx_e_i    = ($urandom_range(0, 1) == 0) ? PI'(m_pidx(pc_r))
                                                         : PI'($urandom_range(0, NP - 1));
            mispredict_e_i = ($urandom_range(0, 3) == 0);
            flush_i        = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
